sdp_ram_fifo_ctrl: RTL and testbench

//  Single-clock synchronous FIFO controller that drives an external simple-dual-port

---
 rtl/sdp_ram_fifo_ctrl.sv | 140 ++++++++++++++
 tb/tb_sdp_ram_fifo_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_fifo_ctrl.sv
// sdp_ram_fifo_ctrl
//  Single-clock FIFO controller around an external simple-dual-port block RAM.
//  Writes go straight to RAM port A; reads are issued on port B and their data is
//  collected into a small register buffer that presents a registered valid/ready
//  output stream. The buffer holds enough entries to cover the RAM read latency, so
//  one word per cycle is sustained even when the consumer stalls intermittently.
//
//  Ports
//   clk, rst            clock and synchronous active-high reset
//   s_data/s_valid/s_ready   write stream (transfer on s_valid & s_ready)
//   m_data/m_valid/m_ready   read stream  (transfer on m_valid & m_ready)
//   count               words held: RAM + reads in flight + output buffer
//   ram_addra/ram_dina/ram_wea            RAM write port A
//   ram_addrb/ram_enb/ram_regceb/ram_rstb RAM read port B controls
//   ram_doutb           RAM read data
module sdp_ram_fifo_ctrl #(
    parameter int DATA_WIDTH  = 36,
    parameter int DEPTH       = 512,
    parameter int RAM_LATENCY = 2,
    localparam int AW         = $clog2(DEPTH),
    localparam int OBUF_DEPTH = RAM_LATENCY + 2,
    localparam int CW         = $clog2(DEPTH + OBUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CW-1:0]         count,
    output logic [AW-1:0]         ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_wea,
    output logic [AW-1:0]         ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    output logic                  ram_rstb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    localparam int OW = $clog2(OBUF_DEPTH + 1);

    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]           credits_q, credits_d;
    logic [OW-1:0]           ocnt_q, ocnt_d;
    logic [RAM_LATENCY-1:0]  vpipe_q, vpipe_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0]   obuf_q [OBUF_DEPTH];
    logic [DATA_WIDTH-1:0]   obuf_d [OBUF_DEPTH];

    logic [AW:0]   fill;
    logic          ram_full;
    logic          wr_en;
    logic          rd_en;
    logic          pop;
    logic          push;
    logic [OW-1:0] push_idx;

    // Handshakes and read issue. Read issue looks only at registered state so the
    // consumer's m_ready never reaches the RAM enable. Credits count every word that
    // has been issued but not yet popped, which bounds the buffer occupancy.
    always_comb begin
        fill     = wr_ptr_q - rd_ptr_q;
        ram_full = (fill == (AW+1)'(DEPTH));
        s_ready  = !rst && !ram_full;
        wr_en    = s_valid && s_ready;
        rd_en    = !rst && (rd_ptr_q != wr_ptr_q) && (credits_q < OW'(OBUF_DEPTH));
        m_valid  = !rst && (ocnt_q != '0);
        pop      = m_valid && m_ready;
        push     = vpipe_q[RAM_LATENCY-1];
    end

    // Next-state for pointers, credits, the read-valid pipe and the word count.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(rd_en);
        credits_d = credits_q + OW'(rd_en) - OW'(pop);
        count_d   = count_q + CW'(wr_en) - CW'(pop);
        vpipe_d   = (vpipe_q << 1) | RAM_LATENCY'(rd_en);
    end

    // Output buffer as a shift-down register FIFO: entry 0 is always the head, so
    // m_data comes straight from a flop. An arriving word lands behind the last
    // valid entry, accounting for a pop in the same cycle.
    always_comb begin
        obuf_d   = obuf_q;
        push_idx = ocnt_q - OW'(pop);
        if (pop) begin
            for (int i = 0; i < OBUF_DEPTH - 1; i++) begin
                obuf_d[i] = obuf_q[i+1];
            end
        end
        for (int i = 0; i < OBUF_DEPTH; i++) begin
            if (push && (push_idx == OW'(i))) begin
                obuf_d[i] = ram_doutb;
            end
        end
        ocnt_d = ocnt_q + OW'(push) - OW'(pop);
    end

    // State registers. Reset also clears the read-valid pipe so data from reads
    // issued before reset is never captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            credits_q <= '0;
            ocnt_q    <= '0;
            vpipe_q   <= '0;
            count_q   <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                obuf_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            credits_q <= credits_d;
            ocnt_q    <= ocnt_d;
            vpipe_q   <= vpipe_d;
            count_q   <= count_d;
            obuf_q    <= obuf_d;
        end
    end

    assign m_data    = obuf_q[0];
    assign count     = count_q;
    assign ram_wea   = wr_en;
    assign ram_addra = wr_ptr_q[AW-1:0];
    assign ram_dina  = s_data;
    assign ram_enb   = rd_en;
    assign ram_addrb = rd_ptr_q[AW-1:0];
    // With an output register, the RAM's internal latch holds the word one cycle
    // after issue; that is when the output register must load it.
    assign ram_regceb = (RAM_LATENCY == 2) ? (!rst && vpipe_q[0]) : 1'b0;
    assign ram_rstb   = rst;

endmodule

// File: tb/tb_sdp_ram_fifo_ctrl.sv
module tb_sdp_ram_fifo_ctrl;

    localparam int DW    = 36;
    localparam int DEPTH = 16;
    localparam int RAND_TARGET = 11100;

    localparam int LIT_NONE  = 0;
    localparam int LIT_RST   = 1;
    localparam int LIT_FULL  = 2;
    localparam int LIT_DRAIN = 3;
    localparam int LIT_END   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          m_ready;

    logic          s_ready_a, m_valid_a, wea_a, enb_a, regceb_a, rstb_a;
    logic [DW-1:0] m_data_a, dina_a, doutb_a;
    logic [4:0]    count_a;
    logic [3:0]    addra_a, addrb_a;

    logic          s_ready_b, m_valid_b, wea_b, enb_b, regceb_b, rstb_b;
    logic [DW-1:0] m_data_b, dina_b, doutb_b;
    logic [4:0]    count_b;
    logic [3:0]    addra_b, addrb_b;

    sdp_ram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RAM_LATENCY(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
        .count(count_a),
        .ram_addra(addra_a), .ram_dina(dina_a), .ram_wea(wea_a),
        .ram_addrb(addrb_a), .ram_enb(enb_a), .ram_regceb(regceb_a),
        .ram_rstb(rstb_a), .ram_doutb(doutb_a)
    );

    sdp_ram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RAM_LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
        .count(count_b),
        .ram_addra(addra_b), .ram_dina(dina_b), .ram_wea(wea_b),
        .ram_addrb(addrb_b), .ram_enb(enb_b), .ram_regceb(regceb_b),
        .ram_rstb(rstb_b), .ram_doutb(doutb_b)
    );

    // Block RAM with internal read latch plus optional output register.
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] lat_a;
    always @(posedge clk) begin
        if (wea_a) mem_a[addra_a] <= dina_a;
        if (enb_a) lat_a <= mem_a[addrb_a];
        if (rstb_a) doutb_a <= '0;
        else if (regceb_a) doutb_a <= lat_a;
    end

    // Block RAM without output register.
    logic [DW-1:0] mem_b [DEPTH];
    always @(posedge clk) begin
        if (wea_b) mem_b[addra_b] <= dina_b;
        if (rstb_b) doutb_b <= '0;
        else if (enb_b) doutb_b <= mem_b[addrb_b];
    end

    // Stimulus-side controls read by the compare process.
    int   lit_sel;
    logic t1_on;
    int   t1_t0;
    logic t5_on;

    // Compare-process state: counters, scoreboards and tallies.
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic [DW-1:0] mq  [2][64];
    int            mwc [2][64];
    int            head [2];
    int            tail [2];
    int            ram_wr_n [2];
    int            ram_rd_n [2];
    int            pop_n [2];
    int            pop_total [2] = '{0, 0};
    int            nf_events [2] = '{0, 0};
    logic          was_nf [2];
    logic          prev_enb [2];
    logic          prev_stall [2];
    logic [DW-1:0] prev_md [2];
    logic          got5a [2] = '{1'b0, 1'b0};

    function automatic void cmp(input string nm, input int g,
                                input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("[TB] FAIL %s inst%0d cyc %0d: got 0x%0h expected 0x%0h",
                         nm, g, cyc, act, exp);
        end
    endfunction

    task automatic checkOutput(input int g, input logic sr, input logic mv,
                               input logic [DW-1:0] md, input logic [4:0] cnt,
                               input logic wea, input logic [3:0] addra,
                               input logic [DW-1:0] dina, input logic enb,
                               input logic [3:0] addrb, input logic regceb,
                               input logic rstb);
        int            lat, obuf, cap, mcount;
        logic          exp_mv;
        logic [DW-1:0] front;
        lat  = (g == 0) ? 2 : 1;
        obuf = lat + 2;
        cap  = DEPTH + obuf;
        if (!t5_on) got5a[g] = 1'b0;
        if (rst) begin
            cmp("rst_s_ready", g, 64'(sr), 64'd0);
            cmp("rst_m_valid", g, 64'(mv), 64'd0);
            cmp("rst_wea", g, 64'(wea), 64'd0);
            cmp("rst_enb", g, 64'(enb), 64'd0);
            cmp("rst_regceb", g, 64'(regceb), 64'd0);
            cmp("rst_rstb", g, 64'(rstb), 64'd1);
            head[g] = 0; tail[g] = 0;
            ram_wr_n[g] = 0; ram_rd_n[g] = 0; pop_n[g] = 0;
            prev_enb[g] = 1'b0; prev_stall[g] = 1'b0; was_nf[g] = 1'b0;
            return;
        end
        mcount = tail[g] - head[g];
        front  = mq[g][head[g] % 64];
        cmp("count", g, 64'(cnt), 64'(mcount));
        cmp("rstb_idle", g, 64'(rstb), 64'd0);
        cmp("capacity", g, 64'(mcount <= cap), 64'd1);
        if (mcount < DEPTH) cmp("s_ready_room", g, 64'(sr), 64'd1);
        if (mcount >= cap) cmp("s_ready_full", g, 64'(sr), 64'd0);
        // The head word is visible exactly once it has had RAM latency + 2 cycles.
        exp_mv = (mcount > 0) && (cyc >= mwc[g][head[g] % 64] + lat + 2);
        cmp("m_valid", g, 64'(mv), 64'(exp_mv));
        if (mv && mcount > 0) cmp("m_data", g, 64'(md), 64'(front));
        if (prev_stall[g]) cmp("m_data_hold", g, 64'(md), 64'(prev_md[g]));
        cmp("wea", g, 64'(wea), 64'(s_valid && sr));
        if (wea) begin
            cmp("addra", g, 64'(addra), 64'(ram_wr_n[g] % DEPTH));
            cmp("dina", g, 64'(dina), 64'(s_data));
        end
        if (enb) begin
            cmp("enb_nonempty", g, 64'(ram_wr_n[g] - ram_rd_n[g] > 0), 64'd1);
            cmp("enb_credit", g, 64'(ram_rd_n[g] - pop_n[g] < obuf), 64'd1);
            cmp("addrb", g, 64'(addrb), 64'(ram_rd_n[g] % DEPTH));
        end
        cmp("regceb", g, 64'(regceb), (lat == 2) ? 64'(prev_enb[g]) : 64'd0);

        if (t1_on) begin
            if (cyc == t1_t0 + 1) cmp("t1_count", g, 64'(cnt), 64'd1);
            if (cyc == t1_t0 + lat + 1) cmp("t1_early", g, 64'(mv), 64'd0);
            if (cyc == t1_t0 + lat + 2) begin
                cmp("t1_valid", g, 64'(mv), 64'd1);
                cmp("t1_data", g, 64'(md), 64'h0A5);
            end
        end
        if (lit_sel == LIT_FULL) begin
            cmp("full_count", g, 64'(cnt), (g == 0) ? 64'd20 : 64'd19);
            cmp("full_model", g, 64'(mcount), (g == 0) ? 64'd20 : 64'd19);
            cmp("full_s_ready", g, 64'(sr), 64'd0);
        end
        if (lit_sel == LIT_RST) begin
            cmp("post_rst_m_valid", g, 64'(mv), 64'd0);
            cmp("post_rst_count", g, 64'(cnt), 64'd0);
            cmp("post_rst_s_ready", g, 64'(sr), 64'd1);
        end
        if (t5_on && !got5a[g] && mv && m_ready) begin
            cmp("t5_first", g, 64'(md), 64'h05A);
            got5a[g] = 1'b1;
        end
        if (lit_sel == LIT_DRAIN || lit_sel == LIT_END)
            cmp("drained", g, 64'(mcount), 64'd0);
        if (lit_sel == LIT_END) begin
            cmp("rand_volume", g, 64'(pop_total[g] >= RAND_TARGET), 64'd1);
            cmp("near_full_cover", g, 64'(nf_events[g] >= 5), 64'd1);
        end

        if (s_valid && sr) begin
            mq[g][tail[g] % 64]  = s_data;
            mwc[g][tail[g] % 64] = cyc;
            tail[g]++;
        end
        if (mv && m_ready) begin
            head[g]++;
            pop_n[g]++;
            pop_total[g]++;
        end
        if (wea) ram_wr_n[g]++;
        if (enb) ram_rd_n[g]++;
        if (mcount >= DEPTH && !was_nf[g]) nf_events[g]++;
        was_nf[g]     = (mcount >= DEPTH);
        prev_enb[g]   = enb;
        prev_stall[g] = mv && !m_ready;
        prev_md[g]    = md;
    endtask

    always @(negedge clk) begin
        checkOutput(0, s_ready_a, m_valid_a, m_data_a, count_a, wea_a, addra_a,
                    dina_a, enb_a, addrb_a, regceb_a, rstb_a);
        checkOutput(1, s_ready_b, m_valid_b, m_data_b, count_b, wea_b, addra_b,
                    dina_b, enb_b, addrb_b, regceb_b, rstb_b);
        cyc++;
    end

    task automatic applyStimulus(input logic r, input logic sv,
                                 input logic [DW-1:0] sd, input logic mr);
        @(posedge clk);
        #1;
        rst     = r;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        lit_sel = LIT_NONE;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((head[0] != tail[0] || head[1] != tail[1]) && n < maxc) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            n++;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        lit_sel = LIT_DRAIN;
    endtask

    initial begin
        int            pv, pr, mode, c;
        logic          sv, mr;
        logic [3:0]    hi;
        logic [31:0]   lo;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        lit_sel = LIT_NONE; t1_on = 1'b0; t1_t0 = 0; t5_on = 1'b0;

        repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        lit_sel = LIT_RST;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Single word latency.
        applyStimulus(1'b0, 1'b1, 36'h0A5, 1'b1);
        t1_on = 1'b1;
        t1_t0 = cyc;
        repeat (8) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        t1_on = 1'b0;

        // Fill to capacity with the consumer stalled, then drain in order.
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 36'(i + 100), 1'b0);
        applyStimulus(1'b0, 1'b1, 36'h999, 1'b0);
        lit_sel = LIT_FULL;
        drain(200);

        // Streaming at full rate on both sides.
        for (int i = 0; i < 1000; i++) applyStimulus(1'b0, 1'b1, 36'(i), 1'b1);
        drain(100);

        // Reset with reads in flight and words buffered.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 36'(i + 500), 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b1, 36'h777, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        lit_sel = LIT_RST;
        t5_on = 1'b1;
        applyStimulus(1'b0, 1'b1, 36'h05A, 1'b1);
        applyStimulus(1'b0, 1'b1, 36'h05B, 1'b1);
        drain(50);
        t5_on = 1'b0;

        // Random traffic with alternating balanced, filling and draining phases.
        c = 0;
        while ((pop_total[0] < RAND_TARGET || pop_total[1] < RAND_TARGET) && c < 60000) begin
            mode = (c / 64) % 4;
            pv = (mode == 1) ? 90 : (mode == 3) ? 15 : 50;
            pr = (mode == 1) ? 15 : (mode == 3) ? 90 : 50;
            sv = ($urandom_range(99, 0) < pv);
            mr = ($urandom_range(99, 0) < pr);
            hi = 4'($urandom_range(15, 0));
            lo = $urandom;
            applyStimulus(1'b0, sv, {hi, lo}, mr);
            c++;
        end
        drain(200);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        lit_sel = LIT_END;
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
